// File: rtl/dm_port_arbiter_if.sv
// Port bundle for the data-memory arbiter: two requester ports plus the
// memory-side bus. The requesters and the memory model sit on the master side;
// the arbiter sits on the slave side.
interface dm_port_arbiter_if;
  // Port 0 (CPU MEM stage)
  logic        req0;
  logic        we0;
  logic [11:0] addr0;
  logic [1:0]  size0;
  logic        uns0;
  logic [31:0] wdata0;
  logic        gnt0;
  logic        rvalid0;
  logic        err0;
  logic [31:0] rdata0;
  // Port 1 (DMA / debug)
  logic        req1;
  logic        we1;
  logic [11:0] addr1;
  logic [1:0]  size1;
  logic        uns1;
  logic [31:0] wdata1;
  logic        gnt1;
  logic        rvalid1;
  logic        err1;
  logic [31:0] rdata1;
  // Memory side
  logic [9:0]  mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_din;
  logic        mem_we;
  logic [31:0] mem_dout;

  modport master (
    output req0, we0, addr0, size0, uns0, wdata0,
    input  gnt0, rvalid0, err0, rdata0,
    output req1, we1, addr1, size1, uns1, wdata1,
    input  gnt1, rvalid1, err1, rdata1,
    input  mem_addr, mem_be, mem_din, mem_we,
    output mem_dout
  );

  modport slave (
    input  req0, we0, addr0, size0, uns0, wdata0,
    output gnt0, rvalid0, err0, rdata0,
    input  req1, we1, addr1, size1, uns1, wdata1,
    output gnt1, rvalid1, err1, rdata1,
    output mem_addr, mem_be, mem_din, mem_we,
    input  mem_dout
  );
endinterface

// File: rtl/dm_port_arbiter.sv
// Two-port round-robin arbiter and access sequencer for the 1024 x 32 data
// memory. Each accepted access spends one ACCESS cycle driving the memory;
// the extended load data (or store completion) is returned one cycle later.
module dm_port_arbiter (
  input logic           clk,
  input logic           rst,
  dm_port_arbiter_if.slave bus
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t state_q, state_d;
  logic   last_gnt_q;

  logic        gnt0, gnt1, accept, acc_port;
  logic        we_s, uns_s, legal_s;
  logic [11:0] addr_s;
  logic [1:0]  size_s;
  logic [31:0] wdata_s;

  // Access captured at the accepting edge, consumed during ACCESS
  logic        port_p0, we_p0, uns_p0, legal_p0;
  logic [1:0]  size_p0, off_p0;

  // Memory-side registers, valid throughout ACCESS
  logic [9:0]  mem_addr_q;
  logic [3:0]  mem_be_q;
  logic [31:0] mem_din_q;
  logic        mem_we_q;

  // Response registers, one cycle after ACCESS
  logic [1:0]  vld_p1;
  logic        err_p1;
  logic [31:0] rdata_p1;

  function automatic logic is_legal(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   return 1'b1;
      2'b01:   return ~off[0];
      2'b10:   return (off == 2'b00);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   return 4'b0001 << off;
      2'b01:   return off[1] ? 4'b1100 : 4'b0011;
      2'b10:   return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] lane_rep(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      2'b00:   return {4{wdata[7:0]}};
      2'b01:   return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [1:0]  size,
                                           input logic [1:0]  off,
                                           input logic        uns,
                                           input logic [31:0] dout);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = 8'(dout >> {off, 3'b000});
    h = 16'(dout >> {off[1], 4'b0000});
    case (size)
      2'b00:   return uns ? {24'h000000, b} : {{24{b[7]}}, b};
      2'b01:   return uns ? {16'h0000, h} : {{16{h[15]}}, h};
      default: return dout;
    endcase
  endfunction

  // Round-robin selection, grant only while IDLE, and the accepted-request mux
  always_comb begin
    gnt0     = (state_q == IDLE) & bus.req0 & (~bus.req1 | last_gnt_q);
    gnt1     = (state_q == IDLE) & bus.req1 & (~bus.req0 | ~last_gnt_q);
    accept   = gnt0 | gnt1;
    acc_port = gnt1;
    we_s     = acc_port ? bus.we1    : bus.we0;
    addr_s   = acc_port ? bus.addr1  : bus.addr0;
    size_s   = acc_port ? bus.size1  : bus.size0;
    uns_s    = acc_port ? bus.uns1   : bus.uns0;
    wdata_s  = acc_port ? bus.wdata1 : bus.wdata0;
    legal_s  = is_legal(size_s, addr_s[1:0]);
  end

  // Next state: ACCESS lasts exactly one cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ACCESS;
      ACCESS:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---- stage p0: accept edge loads memory-side registers; ACCESS clears them
  // ---- stage p1: edge ending ACCESS registers the response for one cycle
  // Control, memory-side and response registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      last_gnt_q <= 1'b1;
      mem_addr_q <= '0;
      mem_be_q   <= '0;
      mem_din_q  <= '0;
      mem_we_q   <= 1'b0;
      vld_p1     <= '0;
      err_p1     <= 1'b0;
      rdata_p1   <= '0;
    end else begin
      state_q  <= state_d;
      vld_p1   <= '0;
      err_p1   <= 1'b0;
      rdata_p1 <= '0;
      if (accept) begin
        last_gnt_q <= acc_port;
        mem_addr_q <= addr_s[11:2];
        mem_be_q   <= legal_s ? byte_en(size_s, addr_s[1:0]) : 4'b0000;
        mem_din_q  <= lane_rep(size_s, wdata_s);
        mem_we_q   <= legal_s & we_s;
      end
      if (state_q == ACCESS) begin
        mem_we_q <= 1'b0;
        mem_be_q <= 4'b0000;
        vld_p1   <= port_p0 ? 2'b10 : 2'b01;
        err_p1   <= ~legal_p0;
        rdata_p1 <= (legal_p0 & ~we_p0) ? load_ext(size_p0, off_p0, uns_p0, bus.mem_dout)
                                        : 32'h0000_0000;
      end
    end
  end

  // Access attributes needed after the accepting edge
  always_ff @(posedge clk) begin
    if (accept) begin
      port_p0  <= acc_port;
      we_p0    <= we_s;
      uns_p0   <= uns_s;
      legal_p0 <= legal_s;
      size_p0  <= size_s;
      off_p0   <= addr_s[1:0];
    end
  end

  assign bus.gnt0     = gnt0;
  assign bus.gnt1     = gnt1;
  assign bus.rvalid0  = vld_p1[0];
  assign bus.rvalid1  = vld_p1[1];
  assign bus.err0     = vld_p1[0] & err_p1;
  assign bus.err1     = vld_p1[1] & err_p1;
  assign bus.rdata0   = vld_p1[0] ? rdata_p1 : 32'h0000_0000;
  assign bus.rdata1   = vld_p1[1] ? rdata_p1 : 32'h0000_0000;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_be   = mem_be_q;
  assign bus.mem_din  = mem_din_q;
  assign bus.mem_we   = mem_we_q;

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Bench for dm_port_arbiter: random and directed traffic on both ports against
// a byte-array reference memory and a transaction-level arbitration model.
module tb_dm_port_arbiter;

  logic clk;
  logic rst;

  dm_port_arbiter_if bus();

  dm_port_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Word memory seen by the DUT, and independent byte-level reference
  logic [31:0] tbmem [1024];
  logic [7:0]  refm  [4096];

  assign bus.mem_dout = tbmem[bus.mem_addr];

  // Requester state per port
  bit          p_req   [2];
  bit          p_we    [2];
  int          p_addr  [2];
  int          p_size  [2];
  bit          p_uns   [2];
  logic [31:0] p_wdata [2];

  // Model state
  bit          m_access;
  int          m_last;
  bit          m_resp_v;
  int          m_resp_port;
  bit          m_resp_err;
  logic [31:0] m_resp_rdata;
  int          a_port, a_addr, a_size;
  bit          a_we, a_uns;
  logic [31:0] a_wdata;

  // Observations from the most recent cycles
  int          obs_g;
  logic [31:0] obs_rdata;
  logic        obs_err;
  logic [3:0]  obs_be;
  logic [31:0] obs_din;
  logic        obs_we;
  logic [9:0]  obs_addr;

  function automatic logic [31:0] init_word(input int w);
    return (32'(w) * 32'h9E37_79B1) ^ 32'hA5C3_1F07;
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic bit legal_f(input int size, input int addr);
    if (size == 3) return 1'b0;
    return (addr % (1 << size)) == 0;
  endfunction

  function automatic logic [3:0] be_f(input int size, input int addr);
    logic [3:0] be;
    be = 4'b0000;
    for (int i = 0; i < (1 << size); i++) be[(addr % 4) + i] = 1'b1;
    return be;
  endfunction

  function automatic logic [31:0] din_f(input int size, input logic [31:0] wdata);
    logic [31:0] d;
    int n;
    n = 1 << size;
    for (int k = 0; k < 4; k++) d[8*k +: 8] = wdata[8*(k % n) +: 8];
    return d;
  endfunction

  function automatic logic [31:0] load_f(input int addr, input int size, input bit uns);
    longint v;
    int n;
    n = 1 << size;
    v = 0;
    for (int i = 0; i < n; i++) v = v | (longint'(refm[addr + i]) << (8 * i));
    if (!uns && v[8*n-1]) v = v - (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  task automatic store_f(input int addr, input int size, input logic [31:0] wdata);
    for (int i = 0; i < (1 << size); i++) refm[addr + i] = wdata[8*i +: 8];
  endtask

  task automatic drive_bus();
    bus.req0   = p_req[0];
    bus.we0    = p_we[0];
    bus.addr0  = 12'(p_addr[0]);
    bus.size0  = 2'(p_size[0]);
    bus.uns0   = p_uns[0];
    bus.wdata0 = p_wdata[0];
    bus.req1   = p_req[1];
    bus.we1    = p_we[1];
    bus.addr1  = 12'(p_addr[1]);
    bus.size1  = 2'(p_size[1]);
    bus.uns1   = p_uns[1];
    bus.wdata1 = p_wdata[1];
  endtask

  task automatic set_txn(input int port, input bit we, input int addr, input int size,
                         input bit uns, input logic [31:0] wdata);
    p_we[port]    = we;
    p_addr[port]  = addr;
    p_size[port]  = size;
    p_uns[port]   = uns;
    p_wdata[port] = wdata;
    p_req[port]   = 1'b1;
  endtask

  task automatic gen_random(input int port);
    int r, sz, ad;
    r  = $urandom_range(0, 9);
    sz = (r < 3) ? 0 : (r < 6) ? 1 : (r < 9) ? 2 : 3;
    ad = 12'h100 + $urandom_range(0, 63);
    if (sz != 3 && $urandom_range(0, 4) != 0) ad = ad & ~((1 << sz) - 1);
    set_txn(port, 1'($urandom_range(0, 1)), ad, sz, 1'($urandom_range(0, 1)), $urandom);
  endtask

  // One clock cycle: drive, check at the falling edge, then advance the model
  task automatic step();
    int g;
    bit lg, nv;
    drive_bus();
    @(negedge clk);
    g = -1;
    if (!m_access) begin
      if (p_req[0] && (!p_req[1] || m_last == 1)) g = 0;
      else if (p_req[1]) g = 1;
    end
    chk("gnt0", bus.gnt0, (g == 0));
    chk("gnt1", bus.gnt1, (g == 1));
    obs_g = bus.gnt0 ? 0 : (bus.gnt1 ? 1 : -1);
    if (m_access) begin
      lg = legal_f(a_size, a_addr);
      chk("mem_we", bus.mem_we, (lg && a_we));
      chk("mem_addr", bus.mem_addr, 32'(a_addr >> 2));
      if (lg) chk("mem_be", bus.mem_be, be_f(a_size, a_addr));
      if (lg && a_we) chk("mem_din", bus.mem_din, din_f(a_size, a_wdata));
      obs_be   = bus.mem_be;
      obs_din  = bus.mem_din;
      obs_we   = bus.mem_we;
      obs_addr = bus.mem_addr;
    end else begin
      chk("idle_we", bus.mem_we, 0);
      chk("idle_be", bus.mem_be, 0);
    end
    chk("rvalid0", bus.rvalid0, (m_resp_v && m_resp_port == 0));
    chk("rvalid1", bus.rvalid1, (m_resp_v && m_resp_port == 1));
    if (m_resp_v) begin
      chk("err", (m_resp_port == 1) ? bus.err1 : bus.err0, m_resp_err);
      chk("rdata", (m_resp_port == 1) ? bus.rdata1 : bus.rdata0, m_resp_rdata);
      obs_rdata = (m_resp_port == 1) ? bus.rdata1 : bus.rdata0;
      obs_err   = (m_resp_port == 1) ? bus.err1 : bus.err0;
    end
    nv = 1'b0;
    if (m_access) begin
      lg           = legal_f(a_size, a_addr);
      m_resp_port  = a_port;
      m_resp_err   = !lg;
      m_resp_rdata = 32'h0;
      if (lg && a_we) store_f(a_addr, a_size, a_wdata);
      else if (lg) m_resp_rdata = load_f(a_addr, a_size, a_uns);
      nv       = 1'b1;
      m_access = 1'b0;
    end else if (g >= 0) begin
      a_port   = g;
      a_we     = p_we[g];
      a_addr   = p_addr[g];
      a_size   = p_size[g];
      a_uns    = p_uns[g];
      a_wdata  = p_wdata[g];
      m_access = 1'b1;
      m_last   = g;
      p_req[g] = 1'b0;
    end
    m_resp_v = nv;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (!p_req[0] && !p_req[1] && !m_access && !m_resp_v) begin
        done = 1'b1;
        break;
      end
      step();
    end
    chk("drain_done", done, 1);
  endtask

  task automatic run_txn(input int port, input bit we, input int addr, input int size,
                         input bit uns, input logic [31:0] wdata);
    set_txn(port, we, addr, size, uns, wdata);
    obs_rdata = 32'hxxxx_xxxx;
    obs_err   = 1'bx;
    drain();
  endtask

  // Memory model: commits enabled bytes at the rising edge
  initial begin
    for (int w = 0; w < 1024; w++) tbmem[w] = init_word(w);
    forever begin
      @(posedge clk);
      if (bus.mem_we)
        for (int b = 0; b < 4; b++)
          if (bus.mem_be[b]) tbmem[bus.mem_addr][8*b +: 8] <= bus.mem_din[8*b +: 8];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w, prior;
    int bad;
    int gseq [$];

    for (int i = 0; i < 4096; i++) begin
      w = init_word(i / 4);
      refm[i] = w[8*(i % 4) +: 8];
    end
    for (int n = 0; n < 2; n++) begin
      p_req[n] = 0; p_we[n] = 0; p_addr[n] = 0; p_size[n] = 0; p_uns[n] = 0; p_wdata[n] = 0;
    end
    m_access = 0; m_last = 1; m_resp_v = 0;
    rst = 1'b1;
    drive_bus();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt0", bus.gnt0, 0);
    chk("rst_gnt1", bus.gnt1, 0);
    chk("rst_rvalid0", bus.rvalid0, 0);
    chk("rst_rvalid1", bus.rvalid1, 0);
    chk("rst_err0", bus.err0, 0);
    chk("rst_err1", bus.err1, 0);
    chk("rst_rdata0", bus.rdata0, 0);
    chk("rst_rdata1", bus.rdata1, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_be", bus.mem_be, 0);
    chk("rst_mem_din", bus.mem_din, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Word store then load on port 0
    run_txn(0, 1, 12'h010, 2, 0, 32'hDEAD_BEEF);
    chk("sw_be", obs_be, 4'b1111);
    chk("sw_addr", obs_addr, 10'h004);
    chk("sw_we", obs_we, 1);
    run_txn(0, 0, 12'h010, 2, 0, 32'h0);
    chk("lw_data", obs_rdata, 32'hDEAD_BEEF);
    chk("lw_err", obs_err, 0);

    // Sub-word stores and load extension
    run_txn(0, 1, 12'h013, 0, 0, 32'h0000_0080);
    chk("sb_be", obs_be, 4'b1000);
    chk("sb_din", obs_din, 32'h8080_8080);
    run_txn(0, 0, 12'h013, 0, 0, 32'h0);
    chk("lb_sext", obs_rdata, 32'hFFFF_FF80);
    run_txn(0, 0, 12'h013, 0, 1, 32'h0);
    chk("lbu_zext", obs_rdata, 32'h0000_0080);
    run_txn(0, 1, 12'h016, 1, 0, 32'h0000_1234);
    chk("sh_be", obs_be, 4'b1100);
    w = init_word(5);
    run_txn(0, 0, 12'h014, 2, 0, 32'h0);
    chk("lw_hi", obs_rdata[31:16], 16'h1234);
    chk("lw_lo", obs_rdata[15:0], w[15:0]);

    // Round-robin with both ports held busy for 8 cycles
    run_txn(1, 0, 12'h000, 2, 0, 32'h0);
    for (int c = 0; c < 8; c++) begin
      for (int n = 0; n < 2; n++) if (!p_req[n]) set_txn(n, 0, 12'h040 + 4 * n, 2, 0, 32'h0);
      step();
      chk("rr_not_both", (obs_g == 0 && bus.gnt1 === 1'b1), 0);
      if (obs_g >= 0) gseq.push_back(obs_g);
    end
    chk("rr_count", gseq.size(), 4);
    for (int i = 0; i < 4 && i < gseq.size(); i++) chk("rr_order", gseq[i], i % 2);
    drain();

    // Misaligned and illegal accesses
    run_txn(0, 1, 12'h002, 2, 0, 32'hCAFE_F00D);
    chk("mis_sw_err", obs_err, 1);
    chk("mis_sw_rdata", obs_rdata, 0);
    run_txn(1, 0, 12'h005, 1, 0, 32'h0);
    chk("mis_lh_err", obs_err, 1);
    chk("mis_lh_rdata", obs_rdata, 0);
    run_txn(0, 1, 12'h008, 3, 0, 32'h1234_5678);
    chk("ill_size_err", obs_err, 1);
    run_txn(0, 0, 12'h000, 2, 0, 32'h0);
    chk("mis_unchanged", obs_rdata, init_word(0));

    // Random traffic on both ports
    for (int c = 0; c < 500; c++) begin
      for (int n = 0; n < 2; n++) if (!p_req[n] && $urandom_range(0, 2) == 0) gen_random(n);
      step();
    end
    drain();

    // Reset in the ACCESS cycle of a store
    prior = load_f(12'h020, 2, 0);
    set_txn(0, 1, 12'h020, 2, 0, 32'h1111_1111);
    step();
    chk("pre_rst_we", bus.mem_we, 1);
    rst = 1'b1;
    #1;
    chk("rst_we_now", bus.mem_we, 0);
    chk("rst_be_now", bus.mem_be, 0);
    m_access = 0; m_resp_v = 0; m_last = 1;
    @(negedge clk);
    chk("rst_no_rvalid", bus.rvalid0, 0);
    @(posedge clk);
    #1;
    chk("rst_no_rvalid2", bus.rvalid0, 0);
    rst = 1'b0;
    set_txn(0, 0, 12'h030, 2, 0, 32'h0);
    set_txn(1, 0, 12'h034, 2, 0, 32'h0);
    step();
    chk("post_rst_first", obs_g, 0);
    drain();
    run_txn(1, 0, 12'h020, 2, 0, 32'h0);
    chk("rst_store_lost", obs_rdata, prior);

    // Final memory image against the byte reference
    bad = 0;
    for (int wi = 0; wi < 1024; wi++)
      if (tbmem[wi] !== {refm[4*wi+3], refm[4*wi+2], refm[4*wi+1], refm[4*wi]}) bad++;
    chk("mem_image", bad, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
